// File: rtl/flash_fetch.sv
// flash_fetch: fetch stage between the program counter and a byte-wide
// program flash. Latches the PC word address, reads the low then the high
// byte and presents the assembled little-endian 16-bit instruction with
// flash_ready until the control unit consumes it.
//
// Optional feature: define FETCH_TIMEOUT_EN to bound each byte read to
// TIMEOUT wait cycles (byte forced to 0x00, sticky fetch_err raised).
// Without it the fetch waits indefinitely and fetch_err is tied low.
//
// Ports:
//   clk          clock, rising edge
//   srst         synchronous active-high reset
//   pc_addr      current PC (word address), sampled only in REQ_LO
//   consume      control unit takes the instruction (pc_inc | pc_load)
//   flash_rd     one-cycle read strobe
//   flash_addr   byte address {word, hi/lo}
//   flash_data   read data from flash
//   flash_valid  read data valid pulse
//   instr        assembled instruction
//   flash_ready  instr valid for the latched word
//   fetch_err    sticky timeout flag
module flash_fetch #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic [ADDR_WIDTH-1:0] pc_addr,
    input  logic                  consume,
    output logic                  flash_rd,
    output logic [ADDR_WIDTH:0]   flash_addr,
    input  logic [7:0]            flash_data,
    input  logic                  flash_valid,
    output logic [15:0]           instr,
    output logic                  flash_ready,
    output logic                  fetch_err
);

    localparam int unsigned BAW = ADDR_WIDTH + 1;

    if ((TIMEOUT < 2) || (TIMEOUT > 255)) begin : g_bad_timeout
        $error("flash_fetch: TIMEOUT must be in 2..255");
    end

    typedef enum logic [2:0] {
        REQ_LO  = 3'd0,
        WAIT_LO = 3'd1,
        REQ_HI  = 3'd2,
        WAIT_HI = 3'd3,
        HOLD    = 3'd4
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] word_q, word_d;
    logic                  rd_q, rd_d;
    logic [BAW-1:0]        addr_q, addr_d;
    logic [15:0]           instr_q, instr_d;
    logic                  ready_q, ready_d;

    logic                  timeout_c;
    logic                  byte_done_c;
    logic [7:0]            byte_c;

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned CW = 8;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    // Valid arriving on the last allowed cycle wins over the timeout.
    assign timeout_c = !flash_valid && (cnt_q == CW'(TIMEOUT - 1));

    // Wait counter: cleared while issuing a request, so it starts at 0 in WAIT_*.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        unique case (state_q)
            REQ_LO, REQ_HI: cnt_d = '0;
            WAIT_LO, WAIT_HI: begin
                if (timeout_c) begin
                    err_d = 1'b1;
                end else if (!flash_valid) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign fetch_err = err_q;
`else
    assign timeout_c = 1'b0;
    assign fetch_err = 1'b0;
`endif

    assign byte_done_c = flash_valid || timeout_c;
    assign byte_c      = flash_valid ? flash_data : 8'h00;

    // State register.
    always_ff @(posedge clk) begin
        if (srst) begin
            state_q <= REQ_LO;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            REQ_LO:  state_d = WAIT_LO;
            WAIT_LO: if (byte_done_c) state_d = REQ_HI;
            REQ_HI:  state_d = WAIT_HI;
            WAIT_HI: if (byte_done_c) state_d = HOLD;
            HOLD:    if (consume) state_d = REQ_LO;
            default: state_d = REQ_LO;
        endcase
    end

    // Output/datapath next values; all outputs leave through registers.
    always_comb begin
        rd_d    = 1'b0;
        addr_d  = addr_q;
        word_d  = word_q;
        instr_d = instr_q;
        ready_d = ready_q;
        unique case (state_q)
            REQ_LO: begin
                word_d = pc_addr;
                addr_d = {pc_addr, 1'b0};
                rd_d   = 1'b1;
            end
            WAIT_LO: begin
                if (byte_done_c) instr_d[7:0] = byte_c;
            end
            REQ_HI: begin
                addr_d = {word_q, 1'b1};
                rd_d   = 1'b1;
            end
            WAIT_HI: begin
                if (byte_done_c) begin
                    instr_d[15:8] = byte_c;
                    ready_d       = 1'b1;
                end
            end
            HOLD: begin
                if (consume) ready_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            word_q  <= '0;
            rd_q    <= 1'b0;
            addr_q  <= '0;
            instr_q <= 16'h0000;
            ready_q <= 1'b0;
        end else begin
            word_q  <= word_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            ready_q <= ready_d;
        end
    end

    assign flash_rd    = rd_q;
    assign flash_addr  = addr_q;
    assign instr       = instr_q;
    assign flash_ready = ready_q;

endmodule

// File: tb/tb_flash_fetch.sv
// Bench for flash_fetch: table of fetch vectors plus hand-written corner
// sequences; a behavioural flash answers strobes with a programmable delay.
module tb_flash_fetch;

    localparam int unsigned AW = 12;

    logic          clk = 1'b0;
    logic          srst;
    logic [AW-1:0] pc_addr;
    logic          consume;
    logic          flash_rd;
    logic [AW:0]   flash_addr;
    logic [7:0]    flash_data;
    logic          flash_valid;
    logic [15:0]   instr;
    logic          flash_ready;
    logic          fetch_err;

    always #5 clk = ~clk;

    flash_fetch #(.ADDR_WIDTH(AW), .TIMEOUT(16)) dut (
        .clk         (clk),
        .srst        (srst),
        .pc_addr     (pc_addr),
        .consume     (consume),
        .flash_rd    (flash_rd),
        .flash_addr  (flash_addr),
        .flash_data  (flash_data),
        .flash_valid (flash_valid),
        .instr       (instr),
        .flash_ready (flash_ready),
        .fetch_err   (fetch_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    function void check(input string name, input int unsigned act, input int unsigned exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    function void note_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: event missing or unexpected", name);
    endfunction

    // Scoreboard queues.
    logic [AW:0] exp_addr_q[$];
    logic [15:0] exp_instr_q[$];

    // Flash model controls.
    logic [7:0] cur_lo = 8'h00;
    logic [7:0] cur_hi = 8'h00;
    int         cur_w  = 1;
    bit         drop_lo = 1'b0;
    logic       model_valid = 1'b0;
    logic [7:0] model_data  = 8'h00;
    logic       inj_valid   = 1'b0;
    logic [7:0] inj_data    = 8'h00;
    bit         pend = 1'b0;
    int         cd   = 0;
    logic [7:0] pend_data = 8'h00;

    assign flash_valid = model_valid | inj_valid;
    assign flash_data  = inj_valid ? inj_data : model_data;

    // Flash: data valid cur_w cycles after the strobe-issuing cycle.
    always @(negedge clk) begin
        logic [7:0] d;
        model_valid = 1'b0;
        if (pend) begin
            cd--;
            if (cd == 0) begin
                model_valid = 1'b1;
                model_data  = pend_data;
                pend        = 1'b0;
            end
        end
        if (flash_rd === 1'b1) begin
            if (exp_addr_q.size() == 0) note_fail("unexpected_rd");
            else check("rd_addr", flash_addr, exp_addr_q.pop_front());
            if (!(drop_lo && !flash_addr[0])) begin
                d = flash_addr[0] ? cur_hi : cur_lo;
                if (cur_w <= 1) begin
                    model_valid = 1'b1;
                    model_data  = d;
                end else begin
                    pend      = 1'b1;
                    cd        = cur_w - 1;
                    pend_data = d;
                end
            end
        end
    end

    // Protocol: consume only while flash_ready is high.
    always @(posedge clk) begin
        if (!srst && consume) check("consume_needs_ready", flash_ready, 1);
    end

    typedef struct {
        logic [AW-1:0] pc;
        logic [7:0]    lo;
        logic [7:0]    hi;
        int            w;
        logic [15:0]   exp_instr;
        logic [AW:0]   a_lo;
        int            exp_lat;
    } vec_t;

    vec_t vecs[6];

    task automatic check_reset(input string tag);
        check({tag, "_rd"},    flash_rd, 0);
        check({tag, "_addr"},  flash_addr, 0);
        check({tag, "_instr"}, instr, 0);
        check({tag, "_ready"}, flash_ready, 0);
        check({tag, "_err"},   fetch_err, 0);
    endtask

    // Waits for flash_ready, checks latency (negedges) and the assembled word.
    task automatic wait_ready(input string name, input int exp_lat, input int start_cnt);
        int cnt = start_cnt;
        while (flash_ready !== 1'b1 && cnt < 300) begin
            @(negedge clk);
            cnt++;
        end
        if (flash_ready !== 1'b1) begin
            note_fail({name, "_ready_timeout"});
        end else begin
            if (exp_lat >= 0) check({name, "_lat"}, cnt, exp_lat);
            if (exp_instr_q.size() == 0) note_fail({name, "_no_exp"});
            else check({name, "_instr"}, instr, exp_instr_q.pop_front());
        end
    endtask

    // Called at a negedge in HOLD: consumes and starts the next fetch.
    task automatic start_fetch(input logic [AW-1:0] pc, input logic [7:0] lo, input logic [7:0] hi,
                               input int w, input logic [AW:0] a_lo, input logic [15:0] exp_i);
        cur_lo = lo;
        cur_hi = hi;
        cur_w  = w;
        exp_addr_q.push_back(a_lo);
        exp_addr_q.push_back(a_lo | 1);
        exp_instr_q.push_back(exp_i);
        pc_addr = pc;
        consume = 1'b1;
        @(negedge clk);
        consume = 1'b0;
        check("ready_drops_after_consume", flash_ready, 0);
        @(negedge clk);
        pc_addr = AW'($urandom);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{12'h080, 8'h34, 8'h12, 1, 16'h1234, 13'h0100, 4};
        vecs[1] = '{12'h081, 8'hCD, 8'hAB, 1, 16'hABCD, 13'h0102, 5};
        vecs[2] = '{12'h7A5, 8'h01, 8'h80, 3, 16'h8001, 13'h0F4A, 9};
        vecs[3] = '{12'hFFF, 8'h5A, 8'hA5, 2, 16'hA55A, 13'h1FFE, 7};
        vecs[4] = '{12'h000, 8'hFF, 8'hFF, 1, 16'hFFFF, 13'h0000, 5};
        vecs[5] = '{12'h555, 8'h00, 8'h00, 4, 16'h0000, 13'h0AAA, 11};

        srst    = 1'b1;
        consume = 1'b0;
        pc_addr = vecs[0].pc;
        repeat (3) @(negedge clk);
        check_reset("reset");

        // Reset release then first fetch.
        cur_lo = vecs[0].lo;
        cur_hi = vecs[0].hi;
        cur_w  = vecs[0].w;
        exp_addr_q.push_back(vecs[0].a_lo);
        exp_addr_q.push_back(vecs[0].a_lo | 1);
        exp_instr_q.push_back(vecs[0].exp_instr);
        srst = 1'b0;
        wait_ready("v0", vecs[0].exp_lat, 0);

        // Stall in HOLD.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_ready", flash_ready, 1);
            check("stall_instr", instr, 16'h1234);
            check("stall_rd", flash_rd, 0);
        end

        for (int i = 1; i < 6; i++) begin
            start_fetch(vecs[i].pc, vecs[i].lo, vecs[i].hi, vecs[i].w, vecs[i].a_lo, vecs[i].exp_instr);
            wait_ready($sformatf("v%0d", i), vecs[i].exp_lat, 2);
        end

        // Stray valid in HOLD must not be captured.
        inj_valid = 1'b1;
        inj_data  = 8'h99;
        @(negedge clk);
        inj_valid = 1'b0;
        @(negedge clk);
        check("hold_inject_instr", instr, 16'h0000);
        check("hold_inject_ready", flash_ready, 1);

`ifdef FETCH_TIMEOUT_EN
        drop_lo = 1'b1;
        start_fetch(12'h2B4, 8'h77, 8'h3C, 1, 13'h0568, 16'h3C00);
        wait_ready("timeout", 20, 2);
        check("timeout_err", fetch_err, 1);
        drop_lo = 1'b0;
        start_fetch(12'h2B5, 8'h10, 8'h20, 1, 13'h056A, 16'h2010);
        wait_ready("after_timeout", 5, 2);
        check("err_sticky", fetch_err, 1);
`else
        drop_lo = 1'b1;
        start_fetch(12'h2B4, 8'h77, 8'h3C, 1, 13'h0568, 16'h3C4D);
        repeat (30) @(negedge clk);
        check("nowait_ready", flash_ready, 0);
        check("nowait_err", fetch_err, 0);
        check("nowait_rd", flash_rd, 0);
        inj_valid = 1'b1;
        inj_data  = 8'h4D;
        drop_lo   = 1'b0;
        @(negedge clk);
        inj_valid = 1'b0;
        wait_ready("late_lo", 3, 1);
        start_fetch(12'h2B5, 8'h10, 8'h20, 1, 13'h056A, 16'h2010);
        wait_ready("after_late", 5, 2);
        check("err_tied", fetch_err, 0);
`endif

        // Reset in WAIT_HI with a late valid pending.
        cur_lo = 8'h11;
        cur_hi = 8'h22;
        cur_w  = 4;
        exp_addr_q.push_back(13'h0786);
        exp_addr_q.push_back(13'h0787);
        pc_addr = 12'h3C3;
        consume = 1'b1;
        @(negedge clk);
        consume = 1'b0;
        begin
            bit found = 1'b0;
            for (int i = 0; i < 50 && !found; i++) begin
                @(negedge clk);
                if (flash_rd === 1'b1 && flash_addr[0] === 1'b1) found = 1'b1;
            end
            if (!found) note_fail("mid_read_hi_strobe");
        end
        srst    = 1'b1;
        pc_addr = 12'h246;
        @(negedge clk);
        check_reset("mid_reset");
        repeat (3) @(negedge clk);
        check("mid_reset_stale_instr", instr, 0);
        srst      = 1'b0;
        inj_valid = 1'b1;
        inj_data  = 8'hEE;
        cur_lo    = 8'h77;
        cur_hi    = 8'h66;
        cur_w     = 1;
        exp_addr_q.push_back(13'h048C);
        exp_addr_q.push_back(13'h048D);
        exp_instr_q.push_back(16'h6677);
        @(negedge clk);
        inj_valid = 1'b0;
        wait_ready("restart", 4, 1);
        check("restart_err", fetch_err, 0);

        repeat (2) @(negedge clk);
        check("addr_queue_empty", exp_addr_q.size(), 0);
        check("instr_queue_empty", exp_instr_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/flash_fetch.md
# flash_fetch

Fetch stage between the program counter and the byte-wide program flash. Latches the 12-bit PC, performs two byte reads (low then high) and assembles a 16-bit instruction. Presents the instruction with `flash_ready`, which is the PC's advance qualifier. Holds the instruction until the control unit consumes it.

## Interface

**Parameters**
- `ADDR_WIDTH`, 12, word (PC) address width.
- `TIMEOUT`, 16, max wait cycles per byte read; used only with `FETCH_TIMEOUT_EN`; legal range 2..255.

**Ports**
- `clk` in 1: single clock; all logic on rising edge.
- `srst` in 1: reset, synchronous, active-high.
- `pc_addr` in ADDR_WIDTH: current PC value.
- `consume` in 1: control unit takes the instruction; this is the OR of `pc_inc` and `pc_load`.
- `flash_rd` out 1: one-cycle read strobe to flash.
- `flash_addr` out ADDR_WIDTH+1: byte address, `{word, 1'b0}` for the low byte and `{word, 1'b1}` for the high byte.
- `flash_data` in 8: read data from flash.
- `flash_valid` in 1: read data valid, one-cycle pulse.
- `instr` out 16: assembled instruction, little-endian (`instr[7:0]` is the low byte).
- `flash_ready` out 1: `instr` is valid for the latched word; high level.
- `fetch_err` out 1: sticky timeout flag.

## Operation

- **States:** `REQ_LO`, `WAIT_LO`, `REQ_HI`, `WAIT_HI`, `HOLD`. All outputs are registered.
- **Reset** (`srst` high at an edge):
  - state goes to `REQ_LO`;
  - `flash_rd`=0, `flash_addr`=0, `instr`=0x0000, `flash_ready`=0, `fetch_err`=0, wait counter=0, latched word=0.
  - Reset mid-read abandons the read. A `flash_valid` arriving later is ignored unless the block is in a `WAIT_*` state.
- **`REQ_LO`:**
  - latch `pc_addr` into the word register;
  - drive `flash_addr={pc_addr,0}` and `flash_rd`=1 for exactly this cycle;
  - go to `WAIT_LO`.
- **`WAIT_LO`:**
  - `flash_rd`=0.
  - On `flash_valid`: `instr[7:0]`<=`flash_data`, go to `REQ_HI`.
  - Otherwise increment the wait counter.
- **`REQ_HI`:** drive `flash_addr={word,1}` and `flash_rd`=1; go to `WAIT_HI`.
- **`WAIT_HI`:** on `flash_valid`: `instr[15:8]`<=`flash_data`, go to `HOLD`.
- **`HOLD`:**
  - `flash_ready`=1 and `instr` stable.
  - On `consume`: `flash_ready`<=0, go to `REQ_LO`.
  - Otherwise stay; the PC does not move.
- **Wait counter:** cleared on entry to each `WAIT_*` state.
- **Ignored inputs:**
  - `flash_valid` in `REQ_*` or `HOLD` is ignored; no data is captured.
  - `consume` outside `HOLD` is ignored. The control unit must never assert it without `flash_ready`, and the bench flags this as a protocol violation.
  - `pc_addr` changes outside `REQ_LO` have no effect; only the value latched in `REQ_LO` is fetched.
- **Wrap-around:** word `2^ADDR_WIDTH-1` reads byte addresses 0x1FFE and 0x1FFF. The block never increments addresses itself, so it has no wrap logic.

## Timing

- **Zero-wait flash** (`flash_valid` the cycle after `flash_rd`):
  - `REQ_LO` c0, `WAIT_LO` c1, `REQ_HI` c2, `WAIT_HI` c3, `HOLD` c4.
  - `flash_ready` is first high in c4.
- **After reset release:** first `flash_rd` in the first cycle with `srst` low. The PC reset value 0x080 gives `flash_addr`=0x100.
- **Consume in `HOLD` at cycle n:**
  - the PC updates at the same edge;
  - `flash_ready`=0 in n+1, and `REQ_LO` samples the new `pc_addr` in n+1;
  - next `flash_ready` in n+5 (zero-wait).
- **No double advance:** `flash_ready` deasserts in the cycle after the consuming edge, so each instruction advances the PC exactly once.
- **Throughput:** 5 cycles per instruction plus flash wait cycles.

## Configuration

- **`FETCH_TIMEOUT_EN` defined:**
  - in `WAIT_*`, if `flash_valid` is still absent when the counter reaches `TIMEOUT-1`, the byte is forced to 0x00;
  - `fetch_err`<=1 (sticky until `srst`) and the FSM advances as if valid;
  - a `flash_valid` in that same cycle takes priority, and no error is raised.
- **Not defined:**
  - `WAIT_*` waits indefinitely;
  - `fetch_err` tied 0; no counter logic is synthesized.

## Test plan

- **Reset then fetch:** release `srst` with `pc_addr`=0x080 and a zero-wait flash returning 0x34 then 0x12 -> `flash_addr` 0x100 then 0x101, `instr`=0x1234, `flash_ready`=1 in the 5th cycle after release.
- **Stall and consume:** hold `consume`=0 for 10 cycles in `HOLD` -> `flash_ready` stays 1, `instr` stable, no `flash_rd`. Then pulse `consume` with the PC moving to 0x081 -> `flash_ready`=0 next cycle, next `flash_addr`=0x102.
- **Wait states:** `flash_valid` 3 cycles after each strobe -> `flash_ready` in the 9th cycle, data correct. A `flash_valid` injected in `HOLD` -> `instr` unchanged.
- **Reset mid-read:** assert `srst` in `WAIT_HI`, then a late `flash_valid` -> outputs at reset values, the stale byte is not captured, and a fresh fetch restarts at `REQ_LO`.
- **Timeout:** with `FETCH_TIMEOUT_EN` and `TIMEOUT`=16, never assert `flash_valid` on the low byte -> 16 wait cycles, then `instr[7:0]`=0x00 and `fetch_err`=1, and the high read proceeds. `fetch_err` clears only on `srst`.
- **Top word:** `pc_addr`=0xFFF -> `flash_addr` 0x1FFE then 0x1FFF, correct assembly.
